// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module      : apb_master_bridge
// Description : APB (AMBA3) requester. Turns one valid/ready command into one
//               SETUP+ACCESS transfer and returns one valid/ready response.
//               Optional access timeout enabled by defining APB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_timeout;
  logic                w_complete;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  // Parameter sanity: a zero timeout would abort before the first ACCESS cycle.
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  // Only IDLE accepts, and never while reset is asserted.
  assign cmd_ready = (r_state == S_IDLE) & presetn;
  assign w_accept  = cmd_valid & cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_timeout;

  // Count ACCESS wait cycles; cleared while in SETUP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Abort on the wait cycle that reaches the limit; pready=1 on that cycle wins.
  assign w_timeout = (r_state == S_ACCESS) && !pready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout flag is captured alongside the rest of the response.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_timeout <= w_timeout;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_timeout   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign w_complete = (r_state == S_ACCESS) && (pready || w_timeout);

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)   w_state_nxt = S_SETUP;
      S_SETUP:                  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_complete) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready)  w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered APB and response outputs, derived from the upcoming state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_psel    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable <= (w_state_nxt == S_ACCESS);
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_complete) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= pready ? pslverr : 1'b1;
        r_rsp_rdata <= (pready && !r_pwrite && !pslverr) ? prdata : '0;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
